// File: rtl/shared_mem_pkg.sv
// Shared types and helpers for the shared_mem_arb multi-port memory.
// Widths, port-id type, pipeline-stage record and the byte-strobe merge.
package shared_mem_pkg;

  localparam int WORD_W      = 32;
  localparam int STRB_W      = 4;
  localparam int MAX_PORTS   = 8;
  localparam int MAX_LATENCY = 4;

  typedef logic [2:0] port_id_t;

  typedef struct packed {
    logic              valid;
    port_id_t          id;
    logic [WORD_W-1:0] rdata;
    logic              err;
  } pipe_stage_t;

  function automatic logic [WORD_W-1:0] merge_strb(input logic [WORD_W-1:0] old_w,
                                                   input logic [WORD_W-1:0] new_w,
                                                   input logic [STRB_W-1:0] strb);
    merge_strb = old_w;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) merge_strb[i*8 +: 8] = new_w[i*8 +: 8];
    end
  endfunction

endpackage

// File: rtl/shared_mem_arb_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts at rr_ptr_q,
// pointer moves to the slot after the winner and holds when nothing is granted.
module rr_arbiter
  import shared_mem_pkg::*;
#(
  parameter int NPORTS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORTS-1:0] req_i,
  output logic [NPORTS-1:0] gnt_o,
  output port_id_t          gnt_idx_o,
  output logic              gnt_vld_o
);

  port_id_t              rr_ptr_q, rr_ptr_d;
  logic [2*NPORTS-1:0]   req_rot;
  int                    slot;
  int                    nxt;

  // Rotate the doubled request vector so bit k is the port k places after the pointer.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    slot      = 0;
    nxt       = 0;
    rr_ptr_d  = rr_ptr_q;
    req_rot   = {req_i, req_i} >> rr_ptr_q;
    for (int k = 0; k < NPORTS; k++) begin
      if (!gnt_vld_o && req_rot[k]) begin
        gnt_vld_o = 1'b1;
        slot      = int'(rr_ptr_q) + k;
        if (slot >= NPORTS) slot = slot - NPORTS;
        gnt_idx_o = port_id_t'(slot);
      end
    end
    for (int p = 0; p < NPORTS; p++) begin
      gnt_o[p] = gnt_vld_o && (gnt_idx_o == port_id_t'(p));
    end
    if (gnt_vld_o) begin
      nxt = int'(gnt_idx_o) + 1;
      if (nxt >= NPORTS) nxt = 0;
      rr_ptr_d = port_id_t'(nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/shared_mem_arb.sv
// Multi-port word memory: round-robin grant, access at the grant edge (read-old),
// LATENCY-deep tagged return pipeline. Optional SHARED_MEM_ERR_EN adds mem_err and err_addr.
module shared_mem_arb
  import shared_mem_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        mem_valid,
  input  logic [WORD_W*NPORTS-1:0] mem_addr,
  input  logic [WORD_W*NPORTS-1:0] mem_wdata,
  input  logic [STRB_W*NPORTS-1:0] mem_wstrb,
  output logic [NPORTS-1:0]        mem_ready,
  output logic [WORD_W*NPORTS-1:0] mem_rdata
`ifdef SHARED_MEM_ERR_EN
  ,
  output logic [NPORTS-1:0]        mem_err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Image preload happens in the simulation harness; the datapath never reads the name.
  localparam bit unused_init_file = (INIT_FILE != "");

  logic [NPORTS-1:0] busy_q, busy_d;
  logic [NPORTS-1:0] eligible, gnt;
  port_id_t          gnt_idx;
  logic              gnt_vld, do_access;

  logic [WORD_W-1:0] sel_addr, sel_wdata;
  logic [STRB_W-1:0] sel_strb;
  logic              in_range;
  logic [AW-1:0]     widx;
  logic [WORD_W-1:0] rd_word;
  logic              unused_addr_lsb;

  logic [WORD_W-1:0] mem_q        [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_hold_q [NPORTS];
  pipe_stage_t       pipe_q       [LATENCY];
  pipe_stage_t       pipe_in, pipe_out;

  // A port may not be re-granted in the cycle its ready pulse is showing.
  assign eligible = mem_valid & ~busy_q & ~mem_ready;

  rr_arbiter #(.NPORTS(NPORTS)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (eligible),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign do_access = gnt_vld & ~reset;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (gnt[p]) begin
        sel_addr  = mem_addr[p*WORD_W +: WORD_W];
        sel_wdata = mem_wdata[p*WORD_W +: WORD_W];
        sel_strb  = mem_wstrb[p*STRB_W +: STRB_W];
      end
    end
  end

  assign unused_addr_lsb = ^sel_addr[1:0];
  assign in_range = {2'b00, sel_addr[WORD_W-1:2]} < 32'(DEPTH_WORDS);
  assign widx     = sel_addr[AW+1:2];
  assign rd_word  = in_range ? mem_q[widx] : '0;

  always_comb begin
    pipe_in.valid = do_access;
    pipe_in.id    = gnt_idx;
    pipe_in.rdata = rd_word;
    pipe_in.err   = ~in_range;
  end

  // Array: not reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (do_access && in_range && (sel_strb != '0)) begin
      mem_q[widx] <= merge_strb(mem_q[widx], sel_wdata, sel_strb);
    end
  end

  // Return pipeline: stage 0 is loaded at the grant edge, the last stage drives ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i].valid <= 1'b0;
    end else begin
      pipe_q[0] <= pipe_in;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign pipe_out = pipe_q[LATENCY-1];

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      mem_ready[p] = pipe_out.valid && (pipe_out.id == port_id_t'(p));
      mem_rdata[p*WORD_W +: WORD_W] = mem_ready[p] ? pipe_out.rdata : rdata_hold_q[p];
    end
  end

  always_comb begin
    busy_d = busy_q & ~mem_ready;
    if (do_access) busy_d = busy_d | gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NPORTS; p++) rdata_hold_q[p] <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (mem_ready[p]) rdata_hold_q[p] <= pipe_out.rdata;
      end
    end
  end

`ifdef SHARED_MEM_ERR_EN
  logic              err_seen_q;
  logic [WORD_W-1:0] err_addr_q;
  logic [WORD_W-1:0] err_addr;

  // Sticky capture of the first offending byte address.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_seen_q <= 1'b0;
      err_addr_q <= '0;
    end else if (do_access && !in_range && !err_seen_q) begin
      err_seen_q <= 1'b1;
      err_addr_q <= sel_addr;
    end
  end

  assign err_addr = err_addr_q;

  always_comb begin
    for (int p = 0; p < NPORTS; p++) mem_err[p] = mem_ready[p] & pipe_out.err;
  end
`else
  logic unused_err;
  assign unused_err = pipe_out.err;
`endif

`ifndef SYNTHESIS
  // A busy requester must keep valid asserted until its ready pulse.
  always @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NPORTS; p++) begin
        assert (!busy_q[p] || mem_ready[p] || mem_valid[p]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_shared_mem_arb.sv
// Directed bench for shared_mem_arb: a 2-port LATENCY=1 instance and a 4-port LATENCY=3 instance.
// Honours SHARED_MEM_ERR_EN when defined for the compile.
module tb_shared_mem_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         a_reset, b_reset;
  logic [1:0]   a_valid, a_ready;
  logic [63:0]  a_addr, a_wdata, a_rdata;
  logic [7:0]   a_strb;
  logic [3:0]   b_valid, b_ready;
  logic [127:0] b_addr, b_wdata, b_rdata;
  logic [15:0]  b_strb;
`ifdef SHARED_MEM_ERR_EN
  logic [1:0]   a_err;
  logic [3:0]   b_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  shared_mem_arb #(.NPORTS(2), .DEPTH_WORDS(256), .LATENCY(1)) dut_a (
    .clk       (clk),
    .reset     (a_reset),
    .mem_valid (a_valid),
    .mem_addr  (a_addr),
    .mem_wdata (a_wdata),
    .mem_wstrb (a_strb),
    .mem_ready (a_ready),
    .mem_rdata (a_rdata)
`ifdef SHARED_MEM_ERR_EN
    ,
    .mem_err   (a_err)
`endif
  );

  shared_mem_arb #(.NPORTS(4), .DEPTH_WORDS(256), .LATENCY(3)) dut_b (
    .clk       (clk),
    .reset     (b_reset),
    .mem_valid (b_valid),
    .mem_addr  (b_addr),
    .mem_wdata (b_wdata),
    .mem_wstrb (b_strb),
    .mem_ready (b_ready),
    .mem_rdata (b_rdata)
`ifdef SHARED_MEM_ERR_EN
    ,
    .mem_err   (b_err)
`endif
  );

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on dut_a port p and wait (bounded) for its ready pulse.
  task automatic req_a(input int p, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rd, output int lat,
                       output logic err);
    a_valid[p]          = 1'b1;
    a_addr[p*32 +: 32]  = addr;
    a_wdata[p*32 +: 32] = wdata;
    a_strb[p*4 +: 4]    = strb;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!a_ready[p] && lat < 20);
    check32("req_a_ready", 32'(a_ready[p]), 32'd1);
    rd  = a_rdata[p*32 +: 32];
    err = 1'b0;
`ifdef SHARED_MEM_ERR_EN
    err = a_err[p];
`endif
    a_valid[p] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    a_reset = 1'b1; b_reset = 1'b1;
    a_valid = '0; a_addr = '0; a_wdata = '0; a_strb = '0;
    b_valid = '0; b_addr = '0; b_wdata = '0; b_strb = '0;
    repeat (3) tick();

    check32("a_rst_ready",  32'(a_ready), 32'd0);
    check32("a_rst_rdata0", a_rdata[31:0], 32'd0);
    check32("a_rst_rdata1", a_rdata[63:32], 32'd0);
    check32("a_rst_ptr",    32'(dut_a.u_arb.rr_ptr_q), 32'd0);
    check32("b_rst_ready",  32'(b_ready), 32'd0);
    check32("b_rst_rdata3", b_rdata[127:96], 32'd0);
    a_reset = 1'b0;

    // Preload addr 400 through port 1, then read it on port 0.
    req_a(1, 32'd400, 32'h1, 4'hF, rd, lat, er);
    check32("wr400_lat", 32'(lat), 32'd1);
    tick();
    req_a(0, 32'd400, 32'h0, 4'h0, rd, lat, er);
    check32("rd400_lat",   32'(lat), 32'd1);
    check32("rd400_data",  rd, 32'h1);
    check32("rd400_p1idl", 32'(a_ready[1]), 32'd0);
    tick();
    check32("rd400_pulse", 32'(a_ready), 32'd0);
    check32("rd400_hold",  a_rdata[31:0], 32'h1);

    // Byte-strobe write on port 1.
    req_a(1, 32'h40, 32'h0, 4'hF, rd, lat, er);
    tick();
    req_a(1, 32'h40, 32'hAABBCCDD, 4'b0101, rd, lat, er);
    check32("strb_ack", rd, 32'h0);
    tick();
    req_a(1, 32'h40, 32'h0, 4'h0, rd, lat, er);
    check32("strb_rd", rd, 32'h00BB00DD);
    check32("ptr_pre_cont", 32'(dut_a.u_arb.rr_ptr_q), 32'd0);
    tick();

    // Contention: both ports valid at the same edge with rr_ptr 0.
    a_valid = 2'b11;
    a_addr  = {32'h40, 32'd400};
    a_strb  = '0;
    tick();
    check32("cont_rdy1",  32'(a_ready), 32'd1);
    check32("cont_rd0",   a_rdata[31:0], 32'h1);
    check32("cont_ptr1",  32'(dut_a.u_arb.rr_ptr_q), 32'd1);
    a_valid[0] = 1'b0;
    tick();
    check32("cont_rdy2",  32'(a_ready), 32'd2);
    check32("cont_rd1",   a_rdata[63:32], 32'h00BB00DD);
    check32("cont_ptr2",  32'(dut_a.u_arb.rr_ptr_q), 32'd0);
    a_valid[1] = 1'b0;
    tick();

    // Out-of-range: 1024 and 1028 alias word 0/1 in the low index bits.
    req_a(0, 32'h0, 32'h12345678, 4'hF, rd, lat, er);
    tick();
    req_a(0, 32'd1024, 32'h0, 4'h0, rd, lat, er);
    check32("oor_rd", rd, 32'h0);
`ifdef SHARED_MEM_ERR_EN
    check32("oor_err", 32'(er), 32'd1);
    check32("oor_eaddr", dut_a.err_addr, 32'd1024);
`endif
    tick();
    req_a(0, 32'd1024, 32'hFFFFFFFF, 4'hF, rd, lat, er);
    check32("oor_wr_ack", rd, 32'h0);
    tick();
    req_a(0, 32'h0, 32'h0, 4'h0, rd, lat, er);
    check32("oor_wr_kept", rd, 32'h12345678);
`ifdef SHARED_MEM_ERR_EN
    check32("inr_err", 32'(er), 32'd0);
`endif
    tick();
    req_a(1, 32'd1028, 32'h0, 4'h0, rd, lat, er);
    check32("oor_rd2", rd, 32'h0);
`ifdef SHARED_MEM_ERR_EN
    check32("oor_err2", 32'(er), 32'd1);
    check32("eaddr_sticky", dut_a.err_addr, 32'd1024);
`endif

    // Fairness on the 4-port, LATENCY=3 instance.
    b_valid = 4'hF;
    b_addr  = {32'hC, 32'h8, 32'h4, 32'h0};
    b_reset = 1'b0;
    repeat (3) tick();
    check32("fair_rdy0", 32'(b_ready), 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check32("fair_rdy", 32'(b_ready), 32'(1 << (i % 4)));
    end
    b_valid = '0;
    b_reset = 1'b1;
    tick();
    tick();
    check32("b_rst2_ready", 32'(b_ready), 32'd0);
    check32("b_rst2_ptr",   32'(dut_b.u_arb.rr_ptr_q), 32'd0);

    // Reset one cycle after a grant: that access never completes.
    b_reset = 1'b0;
    b_valid = 4'b0100;
    b_addr  = {32'h0, 32'h20, 32'h0, 32'h0};
    tick();
    check32("mid_gnt_ptr", 32'(dut_b.u_arb.rr_ptr_q), 32'd3);
    b_reset = 1'b1;
    tick();
    check32("mid_rst_rdy", 32'(b_ready), 32'd0);
    check32("mid_rst_ptr", 32'(dut_b.u_arb.rr_ptr_q), 32'd0);
    b_reset = 1'b0;
    tick();
    check32("mid_drop_rdy", 32'(b_ready), 32'd0);
    check32("mid_regnt_ptr", 32'(dut_b.u_arb.rr_ptr_q), 32'd3);
    tick();
    check32("mid_wait_rdy", 32'(b_ready), 32'd0);
    tick();
    check32("mid_regnt_rdy", 32'(b_ready), 32'b0100);
    b_valid = '0;
    tick();
    check32("mid_done_rdy", 32'(b_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_mem_arb.md
# shared_mem_arb

Parametrised multi-port word memory with round-robin arbitration. It replaces the hand-written dual-`always` memory models that let the CPU and the vector coprocessor share one array. Each of `NPORTS` requesters uses the picorv32 native valid/ready/wstrb handshake. The block serialises them onto a single array port with configurable read latency, byte-strobe writes and deterministic ordering.

## Interface
- `NPORTS`, 2: number of requester ports (1–8).
- `DEPTH_WORDS`, 256: array depth in 32-bit words (power of two).
- `LATENCY`, 1: cycles from grant edge to `mem_ready` (1–4).
- `INIT_FILE`, "": optional `$readmemh` image; empty means the array is zero-filled at time 0.

Ports (flattened per-port buses; port p occupies slice p):
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_valid`  in  NPORTS  request valid per port.
- `mem_addr`  in  32*NPORTS  byte address; bits [1:0] ignored.
- `mem_wdata`  in  32*NPORTS  write data.
- `mem_wstrb`  in  4*NPORTS  byte write enables; 0 means read.
- `mem_ready`  out  NPORTS  one-cycle completion pulse.
- `mem_rdata`  out  32*NPORTS  read data, valid while `mem_ready[p]`=1.
- `mem_err`  out  NPORTS  out-of-range pulse, coincident with `mem_ready[p]`. Present only with `SHARED_MEM_ERR_EN`.

## Operation
- Per-port state is IDLE or BUSY.
  - A port is eligible when `mem_valid[p]`=1, the port is IDLE, and `mem_ready[p]`=0 this cycle (no re-grant in the cycle ready is high).
- Arbitration:
  - At most one grant per cycle.
  - Round-robin starting at pointer `rr_ptr`. After a grant to port g, `rr_ptr` becomes (g+1) mod NPORTS. With no grant, `rr_ptr` holds.
- The granted port moves to BUSY, and its request is accessed at the grant edge:
  - word index = `mem_addr[p] >> 2`;
  - each lane i with `wstrb[i]`=1 writes byte lane i;
  - read data is the word value *before* that edge's write (read-old).
- Request fields travel down a `LATENCY`-stage pipeline tagged with the port id. At the output, `mem_ready[tag]` pulses for one cycle with `mem_rdata[tag]`, and the port returns to IDLE.
- Ordering:
  - Accesses complete in grant order.
  - A read granted after a write observes that write, regardless of port.
- Out-of-range (word index ≥ `DEPTH_WORDS`):
  - still granted and acknowledged;
  - write suppressed;
  - `mem_rdata` = 32'h0.
- Requesters must hold `valid`/`addr`/`wdata`/`wstrb` stable until `ready`. Behaviour when a request is dropped early is undefined and is flagged by an assertion in simulation.
- `mem_rdata[p]` holds its last value between pulses.

## Timing
- Reset values:
  - `mem_ready`=0, `mem_err`=0, `mem_rdata`=0.
  - All ports IDLE, pipeline empty, `rr_ptr`=0.
  - Array contents are NOT reset.
- `LATENCY`=1: valid is sampled at edge k and `mem_ready` is high in the cycle after edge k. This is single-port throughput of one access per 2 cycles, identical to the legacy models.
- Aggregate throughput is one access per cycle when ≥2 ports are requesting.
- Simultaneous requests: the lower index wins only when it is first from `rr_ptr`.
- Worst-case wait for a port from eligibility to grant: NPORTS−1 cycles.
- Reset asserted mid-operation:
  - in-flight accesses are discarded and no `ready` is issued for them;
  - a write already performed at its grant edge stays in the array.
- Reset and grant in the same cycle: reset wins and no write occurs.

## Configuration
- `SHARED_MEM_ERR_EN` defined:
  - `mem_err` port exists and pulses with `ready` for out-of-range accesses;
  - sticky register `err_addr` (first offending byte address) is readable hierarchically for the bench;
  - it is cleared by `reset`.
- `SHARED_MEM_ERR_EN` undefined: no `mem_err` port and no `err_addr`. Out-of-range behaviour is otherwise identical.

## Structure
- Package `shared_mem_pkg`:
  - `WORD_W`=32, `STRB_W`=4, `MAX_PORTS`=8, `MAX_LATENCY`=4;
  - port-id typedef `port_id_t` (3 bits);
  - pipeline-stage struct `{valid, port_id_t id, rdata, err}`.
- Sub-module `rr_arbiter`: NPORTS request vector in, one-hot grant plus grant index out, holds `rr_ptr`, has its own `clk`/`reset`.
- The array, pipeline and port-state registers live in the top module.

## Test plan
- Single port read, `LATENCY`=1: port 0 reads addr 400 holding 32'h1 → `mem_ready[0]` 1 cycle after the sampling edge, `mem_rdata[0]`=32'h1, port 1 idle.
- Byte-strobe write: port 1 writes 32'hAABBCCDD with wstrb 4'b0101 to a word holding 0 → a subsequent read returns 32'h00BB00DD; the write ack `rdata`=0.
- Contention, `NPORTS`=2: both ports valid at edge 1 with `rr_ptr`=0 → port 0 granted at edge 1 and port 1 at edge 2. Readys land in consecutive cycles and `rr_ptr` ends at 0.
- Fairness, `NPORTS`=4, all ports continuously valid → grants 0,1,2,3,0,…; no port waits more than 3 cycles.
- Out-of-range with `SHARED_MEM_ERR_EN`: read of addr 1024 at DEPTH 256 → ready with rdata 0, `mem_err`=1, `err_addr`=1024; a write to that address leaves the array unchanged.
- Reset mid-op, `LATENCY`=3: reset one cycle after a grant → no `ready` ever issued, `rr_ptr`=0. The port is re-granted on its first eligible edge after reset deasserts.
